// File: rtl/cache_pkg.sv
// Shared definitions for the nway_cache data cache.
//   - AddrMode encodings seen from the load/store stage
//   - controller state encoding
//   - access-type decode helpers
package cache_pkg;

   // Store word; every load flavour returns the full word.
   localparam logic [3:0] MODE_SW  = 4'b0111;
   localparam logic [3:0] MODE_LW  = 4'b0000;
   localparam logic [3:0] MODE_LH  = 4'b0001;
   localparam logic [3:0] MODE_LB  = 4'b0010;
   localparam logic [3:0] MODE_LHU = 4'b0101;
   localparam logic [3:0] MODE_LBU = 4'b0110;

   typedef enum logic [1:0] {
      IDLE,
      REFILL,
      WRITE,
      FLUSH
   } state_t;

   function automatic logic is_load(input logic [3:0] mode);
      return (mode == MODE_LW)  || (mode == MODE_LH)  || (mode == MODE_LB) ||
             (mode == MODE_LHU) || (mode == MODE_LBU);
   endfunction

   function automatic logic is_store(input logic [3:0] mode);
      return mode == MODE_SW;
   endfunction

endpackage

// File: rtl/nway_cache_plru.sv
// Tree pseudo-LRU helper for one cache set (purely combinational).
//   tree      : current PLRU bits, heap order (node 0 = root, children 2n+1 / 2n+2)
//   way       : way being accessed (hit or fill)
//   tree_next : tree bits after pointing every node on the path away from `way`
//   victim    : way selected by walking the current tree (bit 0 = go left)
module plru_tree
#(
   parameter int unsigned NUM_WAYS = 4
) (
   input  logic [NUM_WAYS-2:0]         tree,
   input  logic [$clog2(NUM_WAYS)-1:0] way,
   output logic [NUM_WAYS-2:0]         tree_next,
   output logic [$clog2(NUM_WAYS)-1:0] victim
);

   localparam int unsigned LEVELS = $clog2(NUM_WAYS);

   // A node at (level l, position p) lies on the path of `way` when the
   // top l bits of `way` equal p; that node is set to point to the other half.
   always_comb begin
      tree_next = tree;
      for (int unsigned l = 0; l < LEVELS; l++) begin
         for (int unsigned p = 0; p < (1 << l); p++) begin
            if ((32'(way) >> (LEVELS - l)) == p)
               tree_next[(1 << l) - 1 + p] = ~way[LEVELS - 1 - l];
         end
      end
   end

   // Walk from the root, accumulating the chosen path as the victim index.
   always_comb begin
      int unsigned v;
      logic        dir;
      v = 0;
      for (int unsigned l = 0; l < LEVELS; l++) begin
         dir = 1'b0;
         for (int unsigned p = 0; p < (1 << l); p++) begin
            if (v == p)
               dir = tree[(1 << l) - 1 + p];
         end
         v = v * 2 + 32'(dir);
      end
      victim = LEVELS'(v);
   end

endmodule

// File: rtl/nway_cache.sv
// N-way set-associative data cache, one word per line, write-through,
// no write-allocate, tree-PLRU replacement, sequential flush.
//   clk, reset            : clock, synchronous active-high reset
//   AddrMode, A, WD       : core access (type, byte address, store data)
//   flush                 : one-cycle request to invalidate every line
//   hit, stall, out       : lookup hit (IDLE only), core hold, load data
//   mem_req/we/addr/wdata : memory request, held until mem_ack
//   mem_ack, mem_rdata    : memory completion and refill data
//   total_accesses/hits/misses : wrapping performance counters
module nway_cache
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_SETS   = 8,
   parameter int unsigned NUM_WAYS   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            AddrMode,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] WD,
   input  logic                  flush,
   output logic                  hit,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [31:0]           total_accesses,
   output logic [31:0]           total_hits,
   output logic [31:0]           total_misses
);

   localparam int unsigned SET_BITS = $clog2(NUM_SETS);
   localparam int unsigned TAG_BITS = ADDR_WIDTH - SET_BITS - 2;
   localparam int unsigned WAY_BITS = $clog2(NUM_WAYS);
   localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);

   // Line storage
   logic                  valid [NUM_SETS][NUM_WAYS];
   logic [TAG_BITS-1:0]   tags  [NUM_SETS][NUM_WAYS];
   logic [DATA_WIDTH-1:0] data  [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-2:0]   plru  [NUM_SETS];

   state_t state, next_state;

   // Transaction captured when leaving IDLE
   logic [SET_BITS-1:0]   cap_set;
   logic [TAG_BITS-1:0]   cap_tag;
   logic [ADDR_WIDTH-1:0] cap_addr;
   logic [DATA_WIDTH-1:0] cap_wd;
   logic                  cap_hit;
   logic [WAY_BITS-1:0]   cap_way;

   logic                  flush_pend;
   logic [SET_BITS-1:0]   flush_cnt;

   // Lookup on the live address
   logic [SET_BITS-1:0]   set_idx;
   logic [TAG_BITS-1:0]   tag_in;
   logic                  lookup_hit;
   logic [WAY_BITS-1:0]   hit_way;
   logic [DATA_WIDTH-1:0] lookup_data;
   logic                  has_invalid;
   logic [WAY_BITS-1:0]   inv_way;
   logic [WAY_BITS-1:0]   fill_way;

   // PLRU datapath
   logic [SET_BITS-1:0]   sel_set;
   logic [WAY_BITS-1:0]   acc_way;
   logic [NUM_WAYS-2:0]   tree_next;
   logic [WAY_BITS-1:0]   plru_victim;

   // Control strobes from the FSM
   logic capture, plru_upd, fill_en, store_upd, flush_clr;
   logic cnt_acc, cnt_hit, cnt_miss;

   assign set_idx   = A[SET_BITS+1:2];
   assign tag_in    = A[ADDR_WIDTH-1:SET_BITS+2];
   assign mem_addr  = cap_addr;
   assign mem_wdata = cap_wd;

   always_comb begin
      lookup_hit  = 1'b0;
      hit_way     = '0;
      lookup_data = '0;
      has_invalid = 1'b0;
      inv_way     = '0;
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
         if (valid[set_idx][w] && (tags[set_idx][w] == tag_in)) begin
            lookup_hit  = 1'b1;
            hit_way     = WAY_BITS'(w);
            lookup_data = data[set_idx][w];
         end
         if (!valid[set_idx][w] && !has_invalid) begin
            has_invalid = 1'b1;
            inv_way     = WAY_BITS'(w);
         end
      end
      fill_way = has_invalid ? inv_way : plru_victim;
   end

   // In IDLE the tree serves the live set (victim choice, hit update);
   // afterwards it serves the captured set for the completion update.
   assign sel_set = (state == IDLE) ? set_idx : cap_set;
   assign acc_way = (state == IDLE) ? hit_way : cap_way;

   plru_tree #(
      .NUM_WAYS (NUM_WAYS)
   ) u_plru (
      .tree      (plru[sel_set]),
      .way       (acc_way),
      .tree_next (tree_next),
      .victim    (plru_victim)
   );

   always_comb begin
      next_state = state;
      stall      = 1'b0;
      hit        = 1'b0;
      out        = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      capture    = 1'b0;
      plru_upd   = 1'b0;
      fill_en    = 1'b0;
      store_upd  = 1'b0;
      flush_clr  = 1'b0;
      cnt_acc    = 1'b0;
      cnt_hit    = 1'b0;
      cnt_miss   = 1'b0;
      unique case (state)
         IDLE: begin
            if (flush || flush_pend) begin
               stall      = 1'b1;
               next_state = FLUSH;
            end else if (is_load(AddrMode)) begin
               cnt_acc = 1'b1;
               if (lookup_hit) begin
                  hit      = 1'b1;
                  out      = lookup_data;
                  plru_upd = 1'b1;
                  cnt_hit  = 1'b1;
               end else begin
                  stall      = 1'b1;
                  capture    = 1'b1;
                  cnt_miss   = 1'b1;
                  next_state = REFILL;
               end
            end else if (is_store(AddrMode)) begin
               stall      = 1'b1;
               hit        = lookup_hit;
               capture    = 1'b1;
               cnt_acc    = 1'b1;
               cnt_hit    = lookup_hit;
               cnt_miss   = !lookup_hit;
               next_state = WRITE;
            end
         end
         REFILL: begin
            mem_req = 1'b1;
            stall   = 1'b1;
            if (mem_ack) begin
               stall      = 1'b0;
               out        = mem_rdata;
               fill_en    = 1'b1;
               plru_upd   = 1'b1;
               next_state = IDLE;
            end
         end
         WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            stall   = 1'b1;
            if (mem_ack) begin
               stall      = 1'b0;
               store_upd  = cap_hit;
               plru_upd   = cap_hit;
               next_state = IDLE;
            end
         end
         FLUSH: begin
            stall     = 1'b1;
            flush_clr = 1'b1;
            if (flush_cnt == LAST_SET)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         flush_pend     <= 1'b0;
         flush_cnt      <= '0;
         cap_set        <= '0;
         cap_tag        <= '0;
         cap_addr       <= '0;
         cap_wd         <= '0;
         cap_hit        <= 1'b0;
         cap_way        <= '0;
         total_accesses <= '0;
         total_hits     <= '0;
         total_misses   <= '0;
         for (int unsigned s = 0; s < NUM_SETS; s++) begin
            plru[s] <= '0;
            for (int unsigned w = 0; w < NUM_WAYS; w++)
               valid[s][w] <= 1'b0;
         end
      end else begin
         state <= next_state;

         if (state == IDLE && next_state == FLUSH)
            flush_pend <= 1'b0;
         else if (state != IDLE && flush)
            flush_pend <= 1'b1;

         if (state == FLUSH)
            flush_cnt <= flush_cnt + 1'b1;

         if (capture) begin
            cap_set  <= set_idx;
            cap_tag  <= tag_in;
            cap_addr <= A & ~ADDR_WIDTH'(3);
            cap_wd   <= WD;
            cap_hit  <= lookup_hit;
            cap_way  <= lookup_hit ? hit_way : fill_way;
         end

         if (cnt_acc)  total_accesses <= total_accesses + 32'd1;
         if (cnt_hit)  total_hits     <= total_hits + 32'd1;
         if (cnt_miss) total_misses   <= total_misses + 32'd1;

         if (flush_clr) begin
            plru[flush_cnt] <= '0;
            for (int unsigned w = 0; w < NUM_WAYS; w++)
               valid[flush_cnt][w] <= 1'b0;
         end
         if (plru_upd)
            plru[sel_set] <= tree_next;
         if (fill_en)
            valid[cap_set][cap_way] <= 1'b1;
      end
   end

   // Tag/data arrays carry no reset; valid bits qualify them.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (fill_en) begin
            tags[cap_set][cap_way] <= cap_tag;
            data[cap_set][cap_way] <= mem_rdata;
         end else if (store_upd) begin
            data[cap_set][cap_way] <= cap_wd;
         end
      end
   end

endmodule

// File: tb/tb_nway_cache.sv
`timescale 1ns/1ps
module tb_nway_cache;

   localparam logic [3:0] LW  = 4'b0000;
   localparam logic [3:0] SW  = 4'b0111;
   localparam logic [3:0] NOP = 4'b1111;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  AddrMode = NOP;
   logic [31:0] A = '0;
   logic [31:0] WD = '0;
   logic        flush = 1'b0;
   logic        hit, stall, mem_req, mem_we;
   logic [31:0] out, mem_addr, mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] total_accesses, total_hits, total_misses;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   nway_cache #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .NUM_SETS   (4),
      .NUM_WAYS   (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .AddrMode       (AddrMode),
      .A              (A),
      .WD             (WD),
      .flush          (flush),
      .hit            (hit),
      .stall          (stall),
      .out            (out),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .total_accesses (total_accesses),
      .total_hits     (total_hits),
      .total_misses   (total_misses)
   );

   // Memory: acks in the 4th cycle of a held request, logs completed transfers.
   int          mem_cnt = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [31:0] fill_data = '0;
   logic [31:0] rd_addr = '0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;

   always @(posedge clk) begin
      #1;
      mem_ack   = mem_req && (mem_cnt == LAT);
      mem_rdata = mem_ack ? fill_data : 32'h0;
      if (mem_ack) begin
         if (mem_we) begin
            wr_cnt++;
            wr_addr = mem_addr;
            wr_data = mem_wdata;
         end else begin
            rd_cnt++;
            rd_addr = mem_addr;
         end
      end
      mem_cnt = (mem_req && !mem_ack) ? mem_cnt + 1 : 0;
   end

   task automatic apply_reset;
      @(negedge clk);
      reset = 1'b1; AddrMode = NOP; flush = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One core access held until stall drops; returns stall cycles, the data
   // on the completing cycle and hit in the first cycle.
   task automatic access(input logic [3:0] mode, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata,
                         output int n_stall, output logic [31:0] dout,
                         output logic hit0);
      @(negedge clk);
      AddrMode = mode; A = addr; WD = wd; fill_data = rdata;
      #1;
      hit0 = hit;
      n_stall = 0;
      while (stall === 1'b1 && n_stall < 40) begin
         n_stall++;
         @(negedge clk);
         #1;
      end
      dout = out;
      @(negedge clk);
      AddrMode = NOP;
   endtask

   task automatic test_reset;
      apply_reset;
      #1;
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
      n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", hit); end
      n_tests++; if (out !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      n_tests++; if (total_accesses !== 32'd0 || total_hits !== 32'd0 || total_misses !== 32'd0) begin
         n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", total_accesses, total_hits, total_misses);
      end
   endtask

   task automatic test_load_miss;
      int ns; logic [31:0] d; logic h; int r0;
      apply_reset;
      r0 = rd_cnt;
      access(LW, 32'h100, 32'h0, 32'hDEADBEEF, ns, d, h);
      n_tests++; if (ns !== 4) begin n_fail++; $display("FAIL miss_stall: got %0d want 4", ns); end
      n_tests++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL miss_out: got %h want deadbeef", d); end
      n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL miss_hit: got %b want 0", h); end
      n_tests++; if (rd_cnt !== r0 + 1 || rd_addr !== 32'h100) begin
         n_fail++; $display("FAIL miss_mem_read: got %0d reads addr %h want %0d addr 100", rd_cnt - r0, rd_addr, 1);
      end
      access(LW, 32'h100, 32'h0, 32'h0BAD0BAD, ns, d, h);
      n_tests++; if (ns !== 0) begin n_fail++; $display("FAIL rehit_stall: got %0d want 0", ns); end
      n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL rehit_hit: got %b want 1", h); end
      n_tests++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rehit_out: got %h want deadbeef", d); end
      n_tests++; if (rd_cnt !== r0 + 1) begin n_fail++; $display("FAIL rehit_no_mem: got %0d reads want 1", rd_cnt - r0); end
      n_tests++; if (total_accesses !== 32'd2 || total_hits !== 32'd1 || total_misses !== 32'd1) begin
         n_fail++; $display("FAIL miss_counters: got %0d/%0d/%0d want 2/1/1", total_accesses, total_hits, total_misses);
      end
   endtask

   // Set 0 fills ways 0..3 in order; tree (root,left,right) ends 000.
   // Touch 0x000 -> 110, touch 0x020 -> 011: victim goes left then right = way1 (0x010).
   task automatic test_replacement;
      int ns; logic [31:0] d; logic h;
      apply_reset;
      access(LW, 32'h000, 32'h0, 32'hA0000000, ns, d, h);
      access(LW, 32'h010, 32'h0, 32'hA0000010, ns, d, h);
      access(LW, 32'h020, 32'h0, 32'hA0000020, ns, d, h);
      access(LW, 32'h030, 32'h0, 32'hA0000030, ns, d, h);
      access(LW, 32'h000, 32'h0, 32'h0, ns, d, h);
      n_tests++; if (h !== 1'b1 || d !== 32'hA0000000) begin n_fail++; $display("FAIL repl_touch0: got hit %b out %h want 1 a0000000", h, d); end
      access(LW, 32'h020, 32'h0, 32'h0, ns, d, h);
      n_tests++; if (h !== 1'b1 || d !== 32'hA0000020) begin n_fail++; $display("FAIL repl_touch2: got hit %b out %h want 1 a0000020", h, d); end
      access(LW, 32'h040, 32'h0, 32'hA0000040, ns, d, h);
      n_tests++; if (ns !== 4 || d !== 32'hA0000040) begin n_fail++; $display("FAIL repl_fill5: got stall %0d out %h want 4 a0000040", ns, d); end
      access(LW, 32'h000, 32'h0, 32'h0, ns, d, h);
      n_tests++; if (h !== 1'b1 || d !== 32'hA0000000) begin n_fail++; $display("FAIL repl_keep0: got hit %b out %h want 1 a0000000", h, d); end
      access(LW, 32'h030, 32'h0, 32'h0, ns, d, h);
      n_tests++; if (h !== 1'b1 || d !== 32'hA0000030) begin n_fail++; $display("FAIL repl_keep3: got hit %b out %h want 1 a0000030", h, d); end
      access(LW, 32'h040, 32'h0, 32'h0, ns, d, h);
      n_tests++; if (h !== 1'b1 || d !== 32'hA0000040) begin n_fail++; $display("FAIL repl_keep4: got hit %b out %h want 1 a0000040", h, d); end
      access(LW, 32'h010, 32'h0, 32'hB0000010, ns, d, h);
      n_tests++; if (h !== 1'b0 || ns !== 4) begin n_fail++; $display("FAIL repl_evicted1: got hit %b stall %0d want 0 4", h, ns); end
   endtask

   task automatic test_store_hit;
      int ns; logic [31:0] d; logic h; int w0;
      apply_reset;
      access(LW, 32'h200, 32'h0, 32'hCAFE0001, ns, d, h);
      w0 = wr_cnt;
      access(SW, 32'h200, 32'h12345678, 32'h0, ns, d, h);
      n_tests++; if (ns !== 4) begin n_fail++; $display("FAIL sthit_stall: got %0d want 4", ns); end
      n_tests++; if (wr_cnt !== w0 + 1 || wr_addr !== 32'h200 || wr_data !== 32'h12345678) begin
         n_fail++; $display("FAIL sthit_mem_write: got %0d writes %h<=%h want 1 200<=12345678", wr_cnt - w0, wr_addr, wr_data);
      end
      access(LW, 32'h200, 32'h0, 32'h0, ns, d, h);
      n_tests++; if (h !== 1'b1 || ns !== 0 || d !== 32'h12345678) begin
         n_fail++; $display("FAIL sthit_reload: got hit %b stall %0d out %h want 1 0 12345678", h, ns, d);
      end
      n_tests++; if (total_accesses !== 32'd3 || total_hits !== 32'd2 || total_misses !== 32'd1) begin
         n_fail++; $display("FAIL sthit_counters: got %0d/%0d/%0d want 3/2/1", total_accesses, total_hits, total_misses);
      end
   endtask

   task automatic test_store_miss;
      int ns; logic [31:0] d; logic h; int w0;
      apply_reset;
      w0 = wr_cnt;
      access(SW, 32'h300, 32'hA5A5A5A5, 32'h0, ns, d, h);
      n_tests++; if (wr_cnt !== w0 + 1 || wr_addr !== 32'h300 || wr_data !== 32'hA5A5A5A5) begin
         n_fail++; $display("FAIL stmiss_mem_write: got %0d writes %h<=%h want 1 300<=a5a5a5a5", wr_cnt - w0, wr_addr, wr_data);
      end
      access(LW, 32'h300, 32'h0, 32'h00000077, ns, d, h);
      n_tests++; if (h !== 1'b0 || ns !== 4 || d !== 32'h00000077) begin
         n_fail++; $display("FAIL stmiss_no_alloc: got hit %b stall %0d out %h want 0 4 00000077", h, ns, d);
      end
      n_tests++; if (total_accesses !== 32'd2 || total_hits !== 32'd0 || total_misses !== 32'd2) begin
         n_fail++; $display("FAIL stmiss_counters: got %0d/%0d/%0d want 2/0/2", total_accesses, total_hits, total_misses);
      end
   endtask

   task automatic test_flush;
      int ns; logic [31:0] d; logic h;
      apply_reset;
      access(LW, 32'h000, 32'h0, 32'h00000111, ns, d, h);
      access(LW, 32'h004, 32'h0, 32'h00000222, ns, d, h);
      // load 0x008 with a flush pulse in its first REFILL cycle
      @(negedge clk);
      AddrMode = LW; A = 32'h008; fill_data = 32'h00000333;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      ns = 0;
      while (stall === 1'b1 && ns < 40) begin ns++; @(negedge clk); #1; end
      n_tests++; if (out !== 32'h00000333) begin n_fail++; $display("FAIL flush_refill_done: got %h want 00000333", out); end
      @(negedge clk);
      AddrMode = NOP;
      #1;
      ns = 0;
      while (stall === 1'b1 && ns < 40) begin ns++; @(negedge clk); #1; end
      // pending-flush IDLE cycle plus one cycle per set
      n_tests++; if (ns !== 5) begin n_fail++; $display("FAIL flush_stall_len: got %0d want 5", ns); end
      n_tests++; if (total_accesses !== 32'd3 || total_hits !== 32'd0 || total_misses !== 32'd3) begin
         n_fail++; $display("FAIL flush_counters: got %0d/%0d/%0d want 3/0/3", total_accesses, total_hits, total_misses);
      end
      access(LW, 32'h000, 32'h0, 32'h00000444, ns, d, h);
      n_tests++; if (h !== 1'b0 || ns !== 4 || d !== 32'h00000444) begin
         n_fail++; $display("FAIL flush_invalidated: got hit %b stall %0d out %h want 0 4 00000444", h, ns, d);
      end
      // flush together with an access: flush first, then the access misses
      @(negedge clk);
      flush = 1'b1; AddrMode = LW; A = 32'h004; fill_data = 32'h00000555;
      @(negedge clk);
      flush = 1'b0;
      ns = 1;
      #1;
      while (stall === 1'b1 && ns < 40) begin ns++; @(negedge clk); #1; end
      d = out;
      @(negedge clk);
      AddrMode = NOP;
      n_tests++; if (ns !== 9 || d !== 32'h00000555) begin
         n_fail++; $display("FAIL flush_priority: got stall %0d out %h want 9 00000555", ns, d);
      end
      n_tests++; if (total_accesses !== 32'd5 || total_hits !== 32'd0 || total_misses !== 32'd5) begin
         n_fail++; $display("FAIL flush_priority_counters: got %0d/%0d/%0d want 5/0/5", total_accesses, total_hits, total_misses);
      end
   endtask

   task automatic test_reset_mid_refill;
      int ns; logic [31:0] d; logic h; int r0;
      apply_reset;
      r0 = rd_cnt;
      @(negedge clk);
      AddrMode = LW; A = 32'h100; fill_data = 32'h00000055;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_req_active: got %b want 1", mem_req); end
      @(negedge clk);
      reset = 1'b1; AddrMode = NOP;
      @(negedge clk);
      #1;
      n_tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin
         n_fail++; $display("FAIL midrst_dropped: got req %b stall %b want 0 0", mem_req, stall);
      end
      n_tests++; if (total_accesses !== 32'd0 || total_hits !== 32'd0 || total_misses !== 32'd0) begin
         n_fail++; $display("FAIL midrst_counters: got %0d/%0d/%0d want 0/0/0", total_accesses, total_hits, total_misses);
      end
      reset = 1'b0;
      access(LW, 32'h100, 32'h0, 32'h00000066, ns, d, h);
      n_tests++; if (h !== 1'b0 || ns !== 4 || d !== 32'h00000066) begin
         n_fail++; $display("FAIL midrst_no_line: got hit %b stall %0d out %h want 0 4 00000066", h, ns, d);
      end
      n_tests++; if (rd_cnt !== r0 + 1) begin n_fail++; $display("FAIL midrst_read_count: got %0d want 1", rd_cnt - r0); end
   endtask

   initial begin
      test_reset;
      test_load_miss;
      test_replacement;
      test_store_hit;
      test_store_miss;
      test_flush;
      test_reset_mid_refill;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
